// File: rtl/qerv_dbus_ram.sv
// Wishbone-classic data-bus responder backed by a DEPTH x 32 RAM.
// Requests are latched on acceptance. A programmable number of wait states
// follows, then a single-cycle ack is produced. Out-of-range addresses also
// raise a single-cycle err alongside the ack.
module qerv_dbus_ram #(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned AW          = $clog2(DEPTH),
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic [3:0]  i_wb_sel,
    input  logic        i_wb_we,
    input  logic        i_wb_cyc,
    output logic [31:0] o_wb_rdt,
    output logic        o_wb_ack,
    output logic        o_wb_err
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_HOLD} state_t;

    localparam logic [3:0] CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [3:0]  sel_q, sel_d;
    logic        we_q, we_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic [31:0] rdt_q, rdt_d;

    logic [31:0] ram [DEPTH];

    logic [31:0]   cur_adr, cur_dat;
    logic [3:0]    cur_sel;
    logic          cur_we;
    logic          in_range;
    logic [AW-1:0] idx;
    logic          go_ack;
    logic          wr_en;

    // With zero wait states the request goes IDLE->ACK in one edge, before
    // the latch holds it, so the live inputs are used while in IDLE.
    always_comb begin
        cur_adr  = (state_q == S_IDLE) ? i_wb_adr : adr_q;
        cur_dat  = (state_q == S_IDLE) ? i_wb_dat : dat_q;
        cur_sel  = (state_q == S_IDLE) ? i_wb_sel : sel_q;
        cur_we   = (state_q == S_IDLE) ? i_wb_we  : we_q;
        in_range = (cur_adr >> (AW + 2)) == '0;
        idx      = cur_adr[AW+1:2];
    end

    // Next-state and registered-output computation for the request FSM.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        we_d    = we_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        rdt_d   = '0;
        go_ack  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_wb_cyc) begin
                    adr_d = i_wb_adr;
                    dat_d = i_wb_dat;
                    sel_d = i_wb_sel;
                    we_d  = i_wb_we;
                    if (WAIT_STATES == 0) begin
                        go_ack = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            S_WAIT: begin
                if (!i_wb_cyc) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    go_ack = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACK:   state_d = S_HOLD;
            default: state_d = S_IDLE;
        endcase
        if (go_ack) begin
            state_d = S_ACK;
            ack_d   = 1'b1;
            err_d   = !in_range;
            if (in_range && !cur_we) begin
                rdt_d = ram[idx];
            end
        end
        wr_en = go_ack && in_range && cur_we && i_rst_n;
    end

    // FSM state, latched request and registered bus outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdt_q   <= rdt_d;
        end
    end

    // Byte-lane store into the RAM on the edge that enters ACK; contents are not reset.
    always_ff @(posedge i_clk) begin
        for (int unsigned b = 0; b < 4; b++) begin
            if (wr_en && cur_sel[b]) begin
                ram[idx][8*b +: 8] <= cur_dat[8*b +: 8];
            end
        end
    end

    assign o_wb_ack = ack_q;
    assign o_wb_err = err_q;
    assign o_wb_rdt = rdt_q;

endmodule
